// File: rtl/lsu_align_pkg.sv
// ============================================================================
// Module : lsu_align_pkg
// Brief  : Shared types and helpers for the load/store alignment unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_align_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_LO   = 3'd1,
        RD_HI   = 3'd2,
        RD_LAST = 3'd3,
        WR_LO   = 3'd4,
        WR_HI   = 3'd5,
        RESP    = 3'd6
    } lsu_state_e;

    typedef enum logic [1:0] {
        LSU_B = 2'd0,
        LSU_H = 2'd1,
        LSU_W = 2'd2
    } lsu_size_e;

    localparam logic [1:0] c_size_illegal = 2'd3;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            LSU_B:   size_bytes = 3'd1;
            LSU_H:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            LSU_B:   size_mask = 4'b0001;
            LSU_H:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_format.sv
// ============================================================================
// Module : lsu_load_format
// Brief  : Extracts a byte/half/word from a two-word window and extends it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_load_format
    import lsu_align_pkg::*;
(
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_win;
    logic        w_sign;

    always_comb begin
        w_win  = 32'({i_hi, i_lo} >> {i_off, 3'b000});
        w_sign = 1'b0;
        o_data = w_win;
        case (i_size)
            LSU_B: begin
                w_sign = ~i_unsigned & w_win[7];
                o_data = {{24{w_sign}}, w_win[7:0]};
            end
            LSU_H: begin
                w_sign = ~i_unsigned & w_win[15];
                o_data = {{16{w_sign}}, w_win[15:0]};
            end
            default: o_data = w_win;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module : lsu_align
// Brief  : Byte-addressed load/store unit over a word RAM; splits unaligned
//          accesses into two word accesses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_align_pkg::*;
#(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH:0]   i_addr,
    input  logic [DATA_WIDTH:0]   i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [DATA_WIDTH:0]   o_rdata,
    output logic                  o_mem_read_req,
    output logic [ADDR_WIDTH:0]   o_mem_addr,
    input  logic [DATA_WIDTH:0]   i_mem_read_data,
    output logic                  o_mem_write_enable,
    output logic [3:0]            o_mem_byte_enable,
    output logic [DATA_WIDTH:0]   o_mem_write_data
);

    lsu_state_e              state_q;
    logic [ADDR_WIDTH:0]     word_q;
    logic [1:0]              off_q;
    logic [1:0]              size_q;
    logic                    unsigned_q;
    logic                    split_q;
    logic [DATA_WIDTH:0]     lo_q;
    logic [3:0]              hi_be_q;
    logic [DATA_WIDTH:0]     hi_data_q;

    logic [ADDR_WIDTH:0]     w_word;
    logic [2:0]              w_nb;
    logic                    w_split;
    logic [7:0]              w_be8;
    logic [2*DATA_WIDTH+1:0] w_st;
    logic [DATA_WIDTH:0]     w_fmt_hi;
    logic [DATA_WIDTH:0]     w_fmt_lo;
    logic [DATA_WIDTH:0]     w_fmt;

    assign o_busy  = (state_q != IDLE);
    assign w_word  = i_addr >> 2;
    assign w_nb    = size_bytes(i_size);
    assign w_split = ({1'b0, i_addr[1:0]} + w_nb) > 3'd4;
    assign w_be8   = {4'b0000, size_mask(i_size)} << i_addr[1:0];
    assign w_st    = {{(DATA_WIDTH+1){1'b0}}, i_wdata} << {i_addr[1:0], 3'b000};

    // In RD_LAST the last word is still on the RAM bus; earlier words are in lo_q.
    assign w_fmt_lo = split_q ? lo_q : i_mem_read_data;
    assign w_fmt_hi = split_q ? i_mem_read_data : '0;

    lsu_load_format u_fmt (
        .i_hi       (w_fmt_hi),
        .i_lo       (w_fmt_lo),
        .i_off      (off_q),
        .i_size     (size_q),
        .i_unsigned (unsigned_q),
        .o_data     (w_fmt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            word_q             <= '0;
            off_q              <= '0;
            size_q             <= '0;
            unsigned_q         <= 1'b0;
            split_q            <= 1'b0;
            lo_q               <= '0;
            hi_be_q            <= '0;
            hi_data_q          <= '0;
            o_done             <= 1'b0;
            o_err              <= 1'b0;
            o_rdata            <= '0;
            o_mem_read_req     <= 1'b0;
            o_mem_addr         <= '0;
            o_mem_write_enable <= 1'b0;
            o_mem_byte_enable  <= '0;
            o_mem_write_data   <= '0;
        end else if (clk_en) begin
            o_done             <= 1'b0;
            o_err              <= 1'b0;
            o_mem_read_req     <= 1'b0;
            o_mem_addr         <= '0;
            o_mem_write_enable <= 1'b0;
            o_mem_byte_enable  <= '0;
            o_mem_write_data   <= '0;
            case (state_q)
                IDLE: begin
                    if (i_req) begin
                        word_q     <= w_word;
                        off_q      <= i_addr[1:0];
                        size_q     <= i_size;
                        unsigned_q <= i_unsigned;
                        split_q    <= w_split;
                        lo_q       <= '0;
                        hi_be_q    <= w_be8[7:4];
                        hi_data_q  <= w_st[2*DATA_WIDTH+1:DATA_WIDTH+1];
                        if (i_size == c_size_illegal) begin
                            state_q <= RESP;
                            o_done  <= 1'b1;
                            o_err   <= 1'b1;
                            o_rdata <= '0;
                        end else if (i_we) begin
                            state_q            <= WR_LO;
                            o_mem_write_enable <= 1'b1;
                            o_mem_addr         <= w_word;
                            o_mem_byte_enable  <= w_be8[3:0];
                            o_mem_write_data   <= w_st[DATA_WIDTH:0];
                        end else begin
                            state_q        <= RD_LO;
                            o_mem_read_req <= 1'b1;
                            o_mem_addr     <= w_word;
                        end
                    end
                end
                RD_LO: begin
                    if (split_q) begin
                        state_q        <= RD_HI;
                        o_mem_read_req <= 1'b1;
                        o_mem_addr     <= word_q + 1'b1;
                    end else begin
                        state_q <= RD_LAST;
                    end
                end
                RD_HI: begin
                    lo_q    <= i_mem_read_data;
                    state_q <= RD_LAST;
                end
                RD_LAST: begin
                    lo_q    <= w_fmt_lo;
                    o_rdata <= w_fmt;
                    o_done  <= 1'b1;
                    state_q <= RESP;
                end
                WR_LO: begin
                    if (split_q) begin
                        state_q            <= WR_HI;
                        o_mem_write_enable <= 1'b1;
                        o_mem_addr         <= word_q + 1'b1;
                        o_mem_byte_enable  <= hi_be_q;
                        o_mem_write_data   <= hi_data_q;
                    end else begin
                        state_q <= RESP;
                        o_done  <= 1'b1;
                    end
                end
                WR_HI: begin
                    state_q <= RESP;
                    o_done  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_align.sv
// ============================================================================
// Module : tb_lsu_align
// Brief  : Directed vector bench for lsu_align with a word-RAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_align;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [1:0]  i_size = 2'd0;
    logic        i_unsigned = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wdata = 32'd0;
    logic        o_busy, o_done, o_err;
    logic [31:0] o_rdata;
    logic        o_mem_read_req;
    logic [31:0] o_mem_addr;
    logic [31:0] i_mem_read_data = 32'd0;
    logic        o_mem_write_enable;
    logic [3:0]  o_mem_byte_enable;
    logic [31:0] o_mem_write_data;

    lsu_align dut (
        .clk                (clk),
        .rst                (rst),
        .clk_en             (clk_en),
        .i_req              (i_req),
        .i_we               (i_we),
        .i_size             (i_size),
        .i_unsigned         (i_unsigned),
        .i_addr             (i_addr),
        .i_wdata            (i_wdata),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_err              (o_err),
        .o_rdata            (o_rdata),
        .o_mem_read_req     (o_mem_read_req),
        .o_mem_addr         (o_mem_addr),
        .i_mem_read_data    (i_mem_read_data),
        .o_mem_write_enable (o_mem_write_enable),
        .o_mem_byte_enable  (o_mem_byte_enable),
        .o_mem_write_data   (o_mem_write_data)
    );

    always #5 clk = ~clk;

    // Word RAM model, sharing clk_en with the unit; also logs every access.
    logic [31:0] mem [0:511];
    int          rd_cnt, wr_cnt, acc_n;
    logic [31:0] acc_addr [0:1];

    always @(posedge clk) begin
        if (rst && clk_en) begin
            if (o_mem_read_req) begin
                i_mem_read_data <= mem[o_mem_addr[8:0]];
                rd_cnt = rd_cnt + 1;
                if (acc_n < 2) acc_addr[acc_n] = o_mem_addr;
                acc_n = acc_n + 1;
            end
            if (o_mem_write_enable) begin
                for (int b = 0; b < 4; b++)
                    if (o_mem_byte_enable[b])
                        mem[o_mem_addr[8:0]][8*b +: 8] = o_mem_write_data[8*b +: 8];
                wr_cnt = wr_cnt + 1;
                if (acc_n < 2) acc_addr[acc_n] = o_mem_addr;
                acc_n = acc_n + 1;
            end
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] m0;
        logic [31:0] m1;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
        logic [31:0] exp_w0;
        logic [31:0] exp_w1;
    } vec_t;

    vec_t vecs [0:12];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        rd_cnt = 0;
        wr_cnt = 0;
        acc_n  = 0;
        acc_addr[0] = 32'd0;
        acc_addr[1] = 32'd0;
    endtask

    task automatic drive(input vec_t v);
        logic [31:0] w;
        @(negedge clk);
        w = v.addr >> 2;
        mem[w[8:0]] = v.m0;
        w = w + 32'd1;
        mem[w[8:0]] = v.m1;
        clear_log();
        i_we       = v.we;
        i_size     = v.size;
        i_unsigned = v.uns;
        i_addr     = v.addr;
        i_wdata    = v.wdata;
        i_req      = 1'b1;
    endtask

    // Counts edges until o_done is seen just after an edge; 0 means timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!o_done && lat < 20);
        if (!o_done) lat = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          lat;
        logic [31:0] w;
        string       tag;
        tag = $sformatf("v%0d", idx);
        drive(v);
        wait_done(lat);
        i_req = 1'b0;
        check({tag, ".latency"}, lat, v.exp_lat);
        check({tag, ".err"}, {31'd0, o_err}, {31'd0, v.exp_err});
        if (!v.we) check({tag, ".rdata"}, o_rdata, v.exp_rdata);
        check({tag, ".reads"}, rd_cnt, v.exp_rd);
        check({tag, ".writes"}, wr_cnt, v.exp_wr);
        if (v.exp_rd + v.exp_wr >= 1) check({tag, ".addr0"}, acc_addr[0], v.exp_a0);
        if (v.exp_rd + v.exp_wr >= 2) check({tag, ".addr1"}, acc_addr[1], v.exp_a1);
        w = v.addr >> 2;
        check({tag, ".ram_w0"}, mem[w[8:0]], v.exp_w0);
        w = w + 32'd1;
        check({tag, ".ram_w1"}, mem[w[8:0]], v.exp_w1);
        @(posedge clk);
        #1;
        check({tag, ".idle_after"}, {30'd0, o_busy, o_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        clear_log();

        //        we sz u  addr          wdata         m0            m1            rdata         e  lat rd wr a0            a1            w0            w1
        vecs[0]  = '{0, 2, 0, 32'h00000100, 32'h0,        32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 0, 3, 1, 0, 32'h40,       32'h0,        32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{0, 2, 0, 32'h00000103, 32'h0,        32'h44332211, 32'h88776655, 32'h77665544, 0, 4, 2, 0, 32'h40,       32'h41,       32'h44332211, 32'h88776655};
        vecs[2]  = '{0, 1, 0, 32'h00000102, 32'h0,        32'h80FF0000, 32'h00000000, 32'hFFFF80FF, 0, 3, 1, 0, 32'h40,       32'h0,        32'h80FF0000, 32'h00000000};
        vecs[3]  = '{0, 1, 1, 32'h00000102, 32'h0,        32'h80FF0000, 32'h00000000, 32'h000080FF, 0, 3, 1, 0, 32'h40,       32'h0,        32'h80FF0000, 32'h00000000};
        vecs[4]  = '{0, 0, 0, 32'h00000101, 32'h0,        32'h12348578, 32'h00000000, 32'hFFFFFF85, 0, 3, 1, 0, 32'h40,       32'h0,        32'h12348578, 32'h00000000};
        vecs[5]  = '{0, 0, 1, 32'h00000103, 32'h0,        32'hF0000000, 32'h00000000, 32'h000000F0, 0, 3, 1, 0, 32'h40,       32'h0,        32'hF0000000, 32'h00000000};
        vecs[6]  = '{0, 1, 0, 32'h00000103, 32'h0,        32'hAA000000, 32'h0000007F, 32'h00007FAA, 0, 4, 2, 0, 32'h40,       32'h41,       32'hAA000000, 32'h0000007F};
        vecs[7]  = '{1, 1, 0, 32'h00000203, 32'h0000ABCD, 32'h11111111, 32'h22222222, 32'h0,        0, 3, 0, 2, 32'h80,       32'h81,       32'hCD111111, 32'h222222AB};
        vecs[8]  = '{1, 2, 0, 32'h00000300, 32'hCAFEBABE, 32'h00000000, 32'h00000000, 32'h0,        0, 2, 0, 1, 32'hC0,       32'h0,        32'hCAFEBABE, 32'h00000000};
        vecs[9]  = '{1, 0, 0, 32'h00000301, 32'h000000A5, 32'h11223344, 32'h00000000, 32'h0,        0, 2, 0, 1, 32'hC0,       32'h0,        32'h1122A544, 32'h00000000};
        vecs[10] = '{1, 2, 0, 32'h00000302, 32'h55667788, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h0,        0, 3, 0, 2, 32'hC0,       32'hC1,       32'h7788AAAA, 32'hBBBB5566};
        vecs[11] = '{0, 3, 0, 32'h00000100, 32'h0,        32'h01020304, 32'h00000000, 32'h00000000, 1, 1, 0, 0, 32'h0,        32'h0,        32'h01020304, 32'h00000000};
        vecs[12] = '{0, 2, 0, 32'hFFFFFFFE, 32'h0,        32'h22110000, 32'h00004433, 32'h44332211, 0, 4, 2, 0, 32'h3FFFFFFF, 32'h40000000, 32'h22110000, 32'h00004433};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset.ctrl", {29'd0, o_busy, o_done, o_err}, 32'd0);
        check("reset.rdata", o_rdata, 32'd0);
        check("reset.mem_ctrl", {26'd0, o_mem_read_req, o_mem_write_enable, o_mem_byte_enable}, 32'd0);
        check("reset.mem_addr", o_mem_addr, 32'd0);
        check("reset.mem_wdata", o_mem_write_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i <= 12; i++) run_vec(i, vecs[i]);

        // Illegal size with request held through RESP: no re-accept.
        drive(vecs[11]);
        @(posedge clk);
        #1;
        check("hold.done1", {31'd0, o_done}, 32'd1);
        check("hold.err1", {31'd0, o_err}, 32'd1);
        @(posedge clk);
        #1;
        check("hold.resp_ignored", {30'd0, o_busy, o_done}, 32'd0);
        i_req = 1'b0;
        @(posedge clk);
        #1;
        check("hold.stays_idle", {30'd0, o_busy, o_done}, 32'd0);
        check("hold.no_mem", rd_cnt + wr_cnt, 32'd0);

        // Asynchronous reset during RD_HI.
        drive(vecs[1]);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_hi.read_req", {31'd0, o_mem_read_req}, 32'd1);
        check("rst_hi.addr", o_mem_addr, 32'h41);
        #1;
        rst   = 1'b0;
        i_req = 1'b0;
        #1;
        check("rst_hi.busy", {31'd0, o_busy}, 32'd0);
        check("rst_hi.mem", {30'd0, o_mem_read_req, o_done}, 32'd0);
        check("rst_hi.mem_addr", o_mem_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_vec(100, vecs[0]);

        // Clock enable low for five cycles in RD_LO.
        drive(vecs[0]);
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("freeze%0d.ctrl", k), {29'd0, o_busy, o_mem_read_req, o_done}, 32'h6);
            check($sformatf("freeze%0d.addr", k), o_mem_addr, 32'h40);
        end
        clk_en = 1'b1;
        wait_done(lat);
        i_req = 1'b0;
        check("freeze.latency", lat, 32'd2);
        check("freeze.rdata", o_rdata, 32'hDEADBEEF);
        check("freeze.reads", rd_cnt, 32'd1);
        @(posedge clk);
        #1;
        check("freeze.idle_after", {30'd0, o_busy, o_done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
